// File: rtl/bottleneck_responder.sv
// rtl/bottleneck_responder.sv - 16-bit narrow-side slave with wait states and little-endian byte RAM
module bottleneck_responder #(
  parameter int AW   = 12,
  parameter int WAIT = 1
) (
  input  logic          ClkI,
  input  logic          ResetI,
  input  logic [AW-1:0] AdrI,
  input  logic [15:0]   DatI,
  output logic [15:0]   DatO,
  input  logic          WeI,
  input  logic          StbI,
  input  logic          SizI,
  input  logic          SignedI,
  input  logic          StallI,
  output logic          AckO
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WaitL = 4'(WAIT);
  localparam int         Words = 1 << (AW - 1);

  logic [15:0]   mem_q [0:Words-1];
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          ack_q;
  logic [15:0]   dat_q;
  logic          commit;
  logic          mem_we;
  logic [AW-2:0] word_adr;
  logic [15:0]   word_rd;
  logic [7:0]    byte_rd;
  logic [15:0]   rd_val;

  assign word_adr = AdrI[AW-1:1];
  assign word_rd  = mem_q[word_adr];
  assign byte_rd  = AdrI[0] ? word_rd[15:8] : word_rd[7:0];
  assign AckO     = ack_q;
  assign DatO     = dat_q;

  // Counter decrement and the commit decision for the current edge; a low StbI never commits, so abort wins
  always_comb begin
    cnt_d  = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    commit = 1'b0;
    case (state_q)
      S_IDLE:  commit = StbI && (WaitL == 4'd0) && !StallI;
      S_WAIT:  commit = StbI && (cnt_d == 4'd0) && !StallI;
      default: commit = 1'b0;
    endcase
    if (SizI) begin
      rd_val = word_rd;
    end else begin
      rd_val = {(SignedI ? {8{byte_rd[7]}} : 8'h00), byte_rd};
    end
  end

  // Writes are gated by reset so a beat caught by reset never lands in the RAM
  assign mem_we = commit && WeI && !ResetI;

  // Beat sequencer: IDLE samples the request, WAIT counts down or stalls, ACK pulses for one cycle
  always_ff @(posedge ClkI or posedge ResetI) begin
    if (ResetI) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      dat_q   <= 16'h0000;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (StbI) begin
            cnt_q <= WaitL;
            if (commit) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              if (!WeI) dat_q <= rd_val;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!StbI) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (commit) begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
              if (!WeI) dat_q <= rd_val;
            end
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Byte-lane RAM write; a halfword ignores AdrI[0] and fills both lanes
  always_ff @(posedge ClkI) begin
    if (mem_we) begin
      if (SizI || !AdrI[0]) mem_q[word_adr][7:0]  <= DatI[7:0];
      if (SizI)             mem_q[word_adr][15:8] <= DatI[15:8];
      else if (AdrI[0])     mem_q[word_adr][15:8] <= DatI[7:0];
    end
  end

endmodule

// File: tb/tb_bottleneck_responder.sv
// tb/tb_bottleneck_responder.sv - directed self-checking bench for bottleneck_responder
module tb_bottleneck_responder;

  logic        ClkI = 1'b0;
  logic        ResetI = 1'b1;
  logic [11:0] AdrI = '0;
  logic [15:0] DatI = '0;
  logic [15:0] DatO;
  logic        WeI = 1'b0, StbI = 1'b0, SizI = 1'b0, SignedI = 1'b0, StallI = 1'b0, AckO;

  logic [11:0] b_AdrI = '0;
  logic [15:0] b_DatI = '0;
  logic [15:0] b_DatO;
  logic        b_WeI = 1'b0, b_StbI = 1'b0, b_SizI = 1'b1, b_SignedI = 1'b0, b_StallI = 1'b0, b_AckO;

  int checks = 0;
  int failures = 0;

  always #5 ClkI = ~ClkI;

  bottleneck_responder #(.AW(12), .WAIT(1)) u_dut (
    .ClkI(ClkI), .ResetI(ResetI), .AdrI(AdrI), .DatI(DatI), .DatO(DatO),
    .WeI(WeI), .StbI(StbI), .SizI(SizI), .SignedI(SignedI), .StallI(StallI), .AckO(AckO)
  );

  bottleneck_responder #(.AW(12), .WAIT(2)) u_dut2 (
    .ClkI(ClkI), .ResetI(ResetI), .AdrI(b_AdrI), .DatI(b_DatI), .DatO(b_DatO),
    .WeI(b_WeI), .StbI(b_StbI), .SizI(b_SizI), .SignedI(b_SignedI), .StallI(b_StallI), .AckO(b_AckO)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic we, input logic siz, input logic sgn, input logic [11:0] adr,
                      input logic [15:0] dat, output logic [15:0] rd, output int lat);
    AdrI = adr; DatI = dat; WeI = we; SizI = siz; SignedI = sgn; StbI = 1'b1;
    lat = 0;
    do begin
      @(posedge ClkI); #1; lat++;
    end while (!AckO && lat < 40);
    rd = DatO;
    StbI = 1'b0;
    @(posedge ClkI); #1;
  endtask

  task automatic b_beat(input logic we, input logic [11:0] adr, input logic [15:0] dat,
                        output logic [15:0] rd, output int lat);
    b_AdrI = adr; b_DatI = dat; b_WeI = we; b_StbI = 1'b1;
    lat = 0;
    do begin
      @(posedge ClkI); #1; lat++;
    end while (!b_AckO && lat < 40);
    rd = b_DatO;
    b_StbI = 1'b0;
    @(posedge ClkI); #1;
  endtask

  initial begin
    logic [15:0] rd;
    int lat;
    int early;
    logic [11:0] b2b_adr [4];
    logic [15:0] b2b_dat [4];
    b2b_adr = '{12'h106, 12'h104, 12'h102, 12'h100};
    b2b_dat = '{16'hD106, 16'hC104, 16'hB102, 16'hA100};

    repeat (2) @(posedge ClkI);
    #1;
    check("reset_ack", AckO, 0);
    check("reset_dat", DatO, 16'h0000);
    ResetI = 1'b0;
    @(posedge ClkI); #1;

    beat(1, 1, 0, 12'h010, 16'hBEEF, rd, lat);
    check("hw_write_lat", lat, 2);
    check("write_keeps_dat", DatO, 16'h0000);
    beat(0, 1, 0, 12'h010, 16'h0000, rd, lat);
    check("hw_read_lat", lat, 2);
    check("hw_read_data", rd, 16'hBEEF);

    beat(1, 0, 0, 12'h021, 16'h3380, rd, lat);
    beat(1, 0, 0, 12'h020, 16'h447F, rd, lat);
    beat(0, 0, 1, 12'h021, 16'h0000, rd, lat);
    check("byte_signed_odd", rd, 16'hFF80);
    beat(0, 0, 0, 12'h021, 16'h0000, rd, lat);
    check("byte_unsigned_odd", rd, 16'h0080);
    beat(0, 0, 1, 12'h020, 16'h0000, rd, lat);
    check("byte_signed_even", rd, 16'h007F);
    beat(0, 1, 0, 12'h020, 16'h0000, rd, lat);
    check("hw_read_bytes", rd, 16'h807F);
    beat(0, 1, 0, 12'h011, 16'h0000, rd, lat);
    check("hw_unaligned_down", rd, 16'hBEEF);

    for (int i = 0; i < 4; i++) beat(1, 1, 0, b2b_adr[i], b2b_dat[i], rd, lat);
    AdrI = b2b_adr[0]; WeI = 1'b0; SizI = 1'b1; SignedI = 1'b0; StbI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        @(posedge ClkI); #1; lat++;
      end while (!AckO && lat < 40);
      check($sformatf("b2b_gap_%0d", i), lat, (i == 0) ? 2 : 3);
      check($sformatf("b2b_data_%0d", i), DatO, b2b_dat[i]);
      if (i < 3) AdrI = b2b_adr[i+1];
    end
    StbI = 1'b0;
    @(posedge ClkI); #1;
    check("b2b_single_pulse", AckO, 0);

    beat(1, 1, 0, 12'h040, 16'h5A5A, rd, lat);
    AdrI = 12'h040; DatI = 16'h1234; WeI = 1'b1; SizI = 1'b1; StbI = 1'b1;
    @(posedge ClkI); #1;
    StbI = 1'b0;
    @(posedge ClkI); #1;
    check("abort_no_ack_a", AckO, 0);
    @(posedge ClkI); #1;
    check("abort_no_ack_b", AckO, 0);
    check("abort_dat_held", DatO, 16'hA100);
    beat(0, 1, 0, 12'h040, 16'h0000, rd, lat);
    check("abort_no_write", rd, 16'h5A5A);

    b_beat(1, 12'h080, 16'h5555, rd, lat);
    check("w2_write_lat", lat, 3);
    b_AdrI = 12'h080; b_WeI = 1'b0; b_StallI = 1'b1; b_StbI = 1'b1;
    early = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge ClkI); #1;
      if (b_AckO) early++;
    end
    check("stall_no_early_ack", early, 0);
    b_StallI = 1'b0;
    @(posedge ClkI); #1;
    check("stall_ack", b_AckO, 1);
    check("stall_data", b_DatO, 16'h5555);
    b_StbI = 1'b0;
    @(posedge ClkI); #1;
    check("stall_single_pulse", b_AckO, 0);

    beat(1, 1, 0, 12'h060, 16'h1111, rd, lat);
    AdrI = 12'h060; DatI = 16'h2222; WeI = 1'b1; SizI = 1'b1; StbI = 1'b1;
    @(posedge ClkI); #1;
    ResetI = 1'b1;
    #1;
    check("rst_ack", AckO, 0);
    check("rst_dat", DatO, 16'h0000);
    StbI = 1'b0;
    @(posedge ClkI); #1;
    ResetI = 1'b0;
    @(posedge ClkI); #1;
    check("rst_idle_ack", AckO, 0);
    beat(0, 1, 0, 12'h060, 16'h0000, rd, lat);
    check("rst_write_lost", rd, 16'h1111);
    beat(0, 1, 0, 12'h010, 16'h0000, rd, lat);
    check("rst_ram_retained", rd, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bottleneck_responder.md
# bottleneck_responder

Synchronous 16-bit slave that answers the narrow side of the bottleneck bridge: it accepts the byte/halfword beats the bridge issues on its S-port, completes each with a one-cycle acknowledge after a configurable number of wait states, and backs them with a little-endian byte-addressable RAM. It is the responder at the far end of the bridge's slave interface. It serves as the bridge's on-chip narrow memory and as the reference target in bridge-level benches.

## Interface

Parameters:
- AW, 12: byte-address width; RAM holds 2**(AW-1) halfwords.
- WAIT, 1: wait-state cycles inserted before every acknowledge (0..15).

Ports:
- ClkI  in  1  system clock, all state on rising edge.
- ResetI  in  1  asynchronous, active-high reset.
- AdrI  in  AW  byte address of the current beat.
- DatI  in  16  write data; byte writes use DatI[7:0].
- DatO  out  16  read data, registered.
- WeI  in  1  1 = write, 0 = read.
- StbI  in  1  beat request; may stay high across back-to-back beats.
- SizI  in  1  0 = byte, 1 = halfword.
- SignedI  in  1  byte reads: 1 = sign-extend, 0 = zero-extend.
- StallI  in  1  extends the wait phase while high.
- AckO  out  1  one-cycle beat completion.

## Operation

- States: IDLE, WAIT, ACK. Reset forces IDLE, AckO=0, DatO=0, wait counter=0. RAM contents are not cleared.
- IDLE: at an edge with StbI=1, load counter=WAIT. Go to WAIT if WAIT>0 or StallI=1, else ACK.
- WAIT: each edge decrements the counter while it is nonzero. Exit to ACK at the first edge where counter==0 (after the decrement) and StallI=0.
- ACK: AckO=1 for exactly this cycle. The next edge always returns to IDLE.
- StbI=0 sampled in WAIT aborts the beat: return to IDLE, no write, no AckO, DatO unchanged.
- Access commit happens on the edge entering ACK. AdrI/DatI/WeI/SizI/SignedI are sampled at that edge; the master holds them stable while StbI is high.
- Endianness is little-endian: byte at even address = halfword[7:0], odd = halfword[15:8].
- Byte write: updates only the lane selected by AdrI[0] with DatI[7:0].
- Halfword write: updates both lanes, {odd,even} = DatI[15:8],DatI[7:0].
- Byte read: DatO[7:0] = selected byte. DatO[15:8] = {8{byte[7]}} if SignedI else 0.
- Halfword read: DatO = {odd,even}. SignedI is ignored.
- Halfword with AdrI[0]=1: AdrI[0] is ignored (aligned down). The bridge never issues this.
- Writes leave DatO unchanged.
- Address is decoded on AdrI[AW-1:1]. The full AW range maps, so no aliasing or wrap occurs inside the block.

## Timing

- StbI sampled high in IDLE at edge k with StallI=0 gives AckO high in the cycle following edge k+WAIT.
- Per-beat latency is WAIT+1 cycles to ack, plus one mandatory IDLE cycle. The minimum beat-to-beat period is WAIT+2 cycles.
- DatO becomes valid in the ACK cycle and holds until the next read commit.
- Back-to-back beats (bridge 32/64-bit sequences, StbI held high): the new address is sampled in the IDLE cycle after ACK, with no extra gap.
- StallI high at the counter==0 edge holds WAIT. The ack occurs at the first edge with StallI=0.
- ResetI asserted mid-beat: immediate IDLE, AckO drops asynchronously, and any uncommitted write is lost. A write committed on an earlier edge persists.
- Simultaneous StbI fall and counter expiry at the same edge: abort wins, no ack.

## Test plan

- Reset with WAIT=1 -> AckO=0, DatO=0. Halfword write 0xBEEF at 0x010, then halfword read at 0x010 -> AckO at edge k+1, DatO=0xBEEF.
- Byte writes 0x80 at 0x021 and 0x7F at 0x020. Byte read 0x021 with SignedI=1 -> DatO=0xFF80; with SignedI=0 -> 0x0080. Halfword read 0x020 -> 0x807F.
- Four back-to-back halfword reads at 0x106, 0x104, 0x102, 0x100 with StbI held high (bridge 64-bit pattern) -> four AckO pulses spaced WAIT+2 cycles, data matching the preloaded words.
- StallI high for 5 cycles during WAIT with WAIT=2 -> ack delayed exactly until the first edge with StallI=0, a single pulse.
- StbI dropped mid-WAIT on a write of 0x1234 to 0x040 -> no AckO; a later read at 0x040 returns the prior value.
- ResetI pulsed during WAIT of a write -> AckO=0 and state IDLE; the write is absent; RAM data written before the reset is retained.
